wrr_cpu_cfg_responder: RTL and testbench
========================================

WRR_CPU_CFG_RESPONDER -- requirements
Module: wrr_cpu_cfg_responder

Interface
REQ-001 Parameter NUM_PORTS, 8, number of egress ports; selected by index[7:5].
REQ-002 Parameter NUM_CLASSES, 8, classes per port; selected by index[4:0]; class >= NUM_CLASSES is out of range.
REQ-003 Parameter ROUND_W, 11, round counter width.
REQ-004 clk_cp  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 wire_in_cpu_valid  in  1  request strobe, sampled only while wire_out_cpu_ready=1.
REQ-007 wire_in_cpu_index  in  8  {port[2:0], class[4:0]}.
REQ-008 wire_in_cpu_write_sig  in  1  write request.
REQ-009 wire_in_cpu_read_sig  in  1  read request.
REQ-010 wire_in_cpu_config_write  in  9  bit[7:0] config weight; bit[8] reserved, ignored.
REQ-011 wire_out_cpu_ready  out  1  high only in IDLE.
REQ-012 wire_out_cpu_valid  out  1  one-cycle response pulse.
REQ-013 wire_out_cpu_index  out  8  index of the request being answered.
REQ-014 wire_out_cpu_val  out  27  {round[26:16], config[15:8], remain[7:0]}.
REQ-015 wire_in_dp_valid  in  1  data-plane consume strobe, accepted every cycle.
REQ-016 wire_in_dp_index  in  8  entry consumed, same encoding as REQ-007.

Function
REQ-017 Storage: NUM_PORTS*NUM_CLASSES entries of {round, config, remain}, held in flops.
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 Transitions: IDLE->ACCESS on accepted request; ACCESS->RESP always; RESP->IDLE always.
REQ-020 Request acceptance: valid=1 in IDLE with read_sig or write_sig set; valid with neither set is ignored, no response.
REQ-021 Priority: write_sig and read_sig both set means write.
REQ-022 Request capture: index, type and write data registered at acceptance.
REQ-023 Write: applied in ACCESS; config=write[7:0], round=0, remain=0.
REQ-024 Read/write data: captured in ACCESS after any same-cycle write or consume; writes return the new value (write-ack).
REQ-025 Response: wire_out_cpu_valid=1 in RESP only, with captured index and val; latency is 2 cycles from acceptance edge to valid.
REQ-026 Response outputs: index and val hold their last value outside RESP.
REQ-027 Out of range: class >= NUM_CLASSES yields a response with val=27'h7FFFFFF and no state change.
REQ-028 Requests presented while ready=0 are dropped, no response.
REQ-029 Consume, config=0: no change.
REQ-030 Consume, remain>1: remain-1.
REQ-031 Consume, remain<=1: remain=config, round+1.
REQ-032 Round wrap: round wraps 2^ROUND_W-1 -> 0.
REQ-033 Consume to an out-of-range index is ignored.
REQ-034 Collision: CPU write and consume to the same entry in the same cycle means the write wins and the consume is dropped.
REQ-035 Different entries in the same cycle: both apply.

Reset
REQ-036 rst=0 asynchronously clears all entries to 0, FSM to IDLE, ready=1, valid=0, index=0, val=0.
REQ-037 Reset mid-transaction aborts it; no response is issued after release.

Verification
REQ-038 Write {p0c0=5, p0c1=3, p0c2=2, p1c0..2=1}, then read each -> val config field matches, round=0, remain=0, valid exactly 2 cycles after acceptance.
REQ-039 Write p0c0=5, then 3 consumes to index 0 -> read returns round=1, config=5, remain=3 (first consume reloads to 5, then 4, 3).
REQ-040 Read index 8'h08 (class 8) -> one response, val=27'h7FFFFFF, storage unchanged.
REQ-041 Write p1c0=1 and consume index 8'h20 in the same cycle -> read returns round=0, remain=0.
REQ-042 Second request asserted while ready=0 -> exactly one response; read-and-write request -> treated as write-ack.
REQ-043 rst asserted in ACCESS -> no valid pulse; all reads after release return 0.

Source files
------------

// File: rtl/wrr_cpu_cfg_responder.sv
// CPU configuration responder for a weighted-round-robin scheduler table.
// Holds per-(port,class) {round, config, remain} entries, serves CPU reads/writes and data-plane consumes.
module wrr_cpu_cfg_responder #(
    parameter int NUM_PORTS   = 8,
    parameter int NUM_CLASSES = 8,
    parameter int ROUND_W     = 11
) (
    input  logic                 clk_cp,
    input  logic                 rst,
    input  logic                 wire_in_cpu_valid,
    input  logic [7:0]           wire_in_cpu_index,
    input  logic                 wire_in_cpu_write_sig,
    input  logic                 wire_in_cpu_read_sig,
    input  logic [8:0]           wire_in_cpu_config_write,
    output logic                 wire_out_cpu_ready,
    output logic                 wire_out_cpu_valid,
    output logic [7:0]           wire_out_cpu_index,
    output logic [ROUND_W+15:0]  wire_out_cpu_val,
    input  logic                 wire_in_dp_valid,
    input  logic [7:0]           wire_in_dp_index
);

    localparam int ENTRIES = NUM_PORTS * NUM_CLASSES;
    localparam int EIDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int VAL_W   = ROUND_W + 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_r;
    logic [VAL_W-1:0]        mem_r [ENTRIES];
    logic [7:0]              req_index_r;
    logic                    req_write_r;
    logic                    req_in_range_r;
    logic [7:0]              req_cfg_r;

    logic                    dp_hit_s;
    logic                    dp_same_s;
    logic                    wr_hit_s;
    logic [EIDX_W-1:0]       dp_entry_s;
    logic [EIDX_W-1:0]       req_entry_s;
    logic [VAL_W-1:0]        resp_val_s;
    logic                    unused_cfg_bit_s;

    assign unused_cfg_bit_s = wire_in_cpu_config_write[8];

    function automatic logic in_range(input logic [7:0] idx);
        return (int'(idx[7:5]) < NUM_PORTS) && (int'(idx[4:0]) < NUM_CLASSES);
    endfunction

    function automatic logic [EIDX_W-1:0] entry_of(input logic [7:0] idx);
        return EIDX_W'(int'(idx[7:5]) * NUM_CLASSES + int'(idx[4:0]));
    endfunction

    // A consume with remain<=1 reloads from config and starts a new round; config=0 disables the entry.
    function automatic logic [VAL_W-1:0] consume(input logic [VAL_W-1:0] e);
        logic [ROUND_W-1:0] rnd;
        logic [7:0]         cfg;
        logic [7:0]         rem;
        {rnd, cfg, rem} = e;
        if (cfg == 8'd0) begin
            return e;
        end else if (rem > 8'd1) begin
            return {rnd, cfg, rem - 8'd1};
        end else begin
            return {rnd + ROUND_W'(1), cfg, cfg};
        end
    endfunction

    // Hit decode and the post-update value of the entry being answered.
    always_comb begin
        dp_hit_s    = wire_in_dp_valid && in_range(wire_in_dp_index);
        dp_entry_s  = entry_of(wire_in_dp_index);
        req_entry_s = entry_of(req_index_r);
        wr_hit_s    = (state_r == ACCESS) && req_write_r && req_in_range_r;
        dp_same_s   = dp_hit_s && (dp_entry_s == req_entry_s);
        if (!req_in_range_r) begin
            resp_val_s = {VAL_W{1'b1}};
        end else if (req_write_r) begin
            resp_val_s = {{ROUND_W{1'b0}}, req_cfg_r, 8'd0};
        end else if (dp_same_s) begin
            resp_val_s = consume(mem_r[req_entry_s]);
        end else begin
            resp_val_s = mem_r[req_entry_s];
        end
    end

    // Entry storage: a CPU write beats a same-entry consume in the same cycle.
    always_ff @(posedge clk_cp or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                mem_r[e] <= {VAL_W{1'b0}};
            end
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (wr_hit_s && (req_entry_s == EIDX_W'(e))) begin
                    mem_r[e] <= {{ROUND_W{1'b0}}, req_cfg_r, 8'd0};
                end else if (dp_hit_s && (dp_entry_s == EIDX_W'(e))) begin
                    mem_r[e] <= consume(mem_r[e]);
                end
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk_cp or negedge rst) begin
        if (!rst) begin
            state_r            <= IDLE;
            wire_out_cpu_ready <= 1'b1;
            wire_out_cpu_valid <= 1'b0;
            wire_out_cpu_index <= 8'd0;
            wire_out_cpu_val   <= {VAL_W{1'b0}};
            req_index_r        <= 8'd0;
            req_write_r        <= 1'b0;
            req_in_range_r     <= 1'b0;
            req_cfg_r          <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wire_in_cpu_valid && (wire_in_cpu_write_sig || wire_in_cpu_read_sig)) begin
                        state_r            <= ACCESS;
                        wire_out_cpu_ready <= 1'b0;
                        req_index_r        <= wire_in_cpu_index;
                        req_write_r        <= wire_in_cpu_write_sig;
                        req_in_range_r     <= in_range(wire_in_cpu_index);
                        req_cfg_r          <= wire_in_cpu_config_write[7:0];
                    end
                end
                ACCESS: begin
                    state_r            <= RESP;
                    wire_out_cpu_valid <= 1'b1;
                    wire_out_cpu_index <= req_index_r;
                    wire_out_cpu_val   <= resp_val_s;
                end
                RESP: begin
                    state_r            <= IDLE;
                    wire_out_cpu_valid <= 1'b0;
                    wire_out_cpu_ready <= 1'b1;
                end
                default: begin
                    state_r            <= IDLE;
                    wire_out_cpu_valid <= 1'b0;
                    wire_out_cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_cpu_cfg_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a table-level reference model.
module tb_wrr_cpu_cfg_responder;

    logic        clk_cp = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [7:0]  cpu_index;
    logic        cpu_write;
    logic        cpu_read;
    logic [8:0]  cpu_wdata;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_index;
    logic [26:0] out_val;
    logic        dp_valid;
    logic [7:0]  dp_index;

    int n_cmp = 0;
    int n_err = 0;

    int m_rnd [64];
    int m_cfg [64];
    int m_rem [64];

    logic [26:0] got_val;

    wrr_cpu_cfg_responder dut (
        .clk_cp                   (clk_cp),
        .rst                      (rst),
        .wire_in_cpu_valid        (cpu_valid),
        .wire_in_cpu_index        (cpu_index),
        .wire_in_cpu_write_sig    (cpu_write),
        .wire_in_cpu_read_sig     (cpu_read),
        .wire_in_cpu_config_write (cpu_wdata),
        .wire_out_cpu_ready       (out_ready),
        .wire_out_cpu_valid       (out_valid),
        .wire_out_cpu_index       (out_index),
        .wire_out_cpu_val         (out_val),
        .wire_in_dp_valid         (dp_valid),
        .wire_in_dp_index         (dp_index)
    );

    always #5 clk_cp = ~clk_cp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit inr(input logic [7:0] idx);
        return idx[4:0] < 5'd8;
    endfunction

    function automatic int ent(input logic [7:0] idx);
        return int'(idx[7:5]) * 8 + int'(idx[4:0]);
    endfunction

    function automatic logic [26:0] model_val(input logic [7:0] idx);
        int e;
        if (!inr(idx)) return 27'h7FFFFFF;
        e = ent(idx);
        return {11'(m_rnd[e]), 8'(m_cfg[e]), 8'(m_rem[e])};
    endfunction

    task automatic model_clear();
        for (int e = 0; e < 64; e++) begin
            m_rnd[e] = 0; m_cfg[e] = 0; m_rem[e] = 0;
        end
    endtask

    task automatic model_consume(input int e);
        if (m_cfg[e] == 0) begin
        end else if (m_rem[e] > 1) begin
            m_rem[e] = m_rem[e] - 1;
        end else begin
            m_rem[e] = m_cfg[e];
            m_rnd[e] = (m_rnd[e] + 1) % 2048;
        end
    endtask

    // One clock: present dp stimulus, mirror the table update at the edge, return at the next negedge.
    task automatic cycle(input bit dpv, input logic [7:0] dpi, input bit wr_now,
                         input logic [7:0] wr_idx, input logic [7:0] wr_data);
        bit wr_ok;
        dp_valid = dpv;
        dp_index = dpi;
        @(posedge clk_cp);
        wr_ok = wr_now && inr(wr_idx);
        if (wr_ok) begin
            m_cfg[ent(wr_idx)] = int'(wr_data);
            m_rnd[ent(wr_idx)] = 0;
            m_rem[ent(wr_idx)] = 0;
        end
        if (dpv && inr(dpi) && !(wr_ok && ent(dpi) == ent(wr_idx))) model_consume(ent(dpi));
        @(negedge clk_cp);
        dp_valid = 1'b0;
    endtask

    task automatic rand_dp(output bit v, output logic [7:0] i);
        v = 1'($urandom_range(0, 1));
        i = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 9))};
    endtask

    // Full CPU transaction; spam keeps a second request asserted while ready is low.
    task automatic do_req(input logic [7:0] idx, input bit wr, input bit rd, input logic [8:0] data,
                          input bit dp0v, input logic [7:0] dp0i,
                          input bit dp1v, input logic [7:0] dp1i, input bit spam);
        logic [26:0] exp;
        check("ready_before_req", 32'(out_ready), 32'd1);
        cpu_valid = 1'b1; cpu_index = idx; cpu_write = wr; cpu_read = rd; cpu_wdata = data;
        cycle(dp0v, dp0i, 1'b0, 8'd0, 8'd0);
        cpu_valid = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
        if (!(wr || rd)) begin
            check("noop_no_valid", 32'(out_valid), 32'd0);
            check("noop_ready", 32'(out_ready), 32'd1);
            return;
        end
        check("access_valid_low", 32'(out_valid), 32'd0);
        check("access_ready_low", 32'(out_ready), 32'd0);
        if (spam) begin
            cpu_valid = 1'b1; cpu_write = 1'b1; cpu_index = idx ^ 8'h01; cpu_wdata = 9'h0AA;
        end
        cycle(dp1v, dp1i, wr, idx, data[7:0]);
        exp = model_val(idx);
        got_val = out_val;
        check("resp_valid", 32'(out_valid), 32'd1);
        check("resp_index", 32'(out_index), 32'(idx));
        check("resp_val", 32'(out_val), 32'(exp));
        cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        cpu_valid = 1'b0; cpu_write = 1'b0;
        check("resp_one_cycle", 32'(out_valid), 32'd0);
        check("ready_back", 32'(out_ready), 32'd1);
        check("index_hold", 32'(out_index), 32'(idx));
        check("val_hold", 32'(out_val), 32'(exp));
        if (spam) begin
            cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
            check("spam_no_extra_resp", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic wr_req(input logic [7:0] idx, input logic [7:0] d);
        do_req(idx, 1'b1, 1'b0, {1'b0, d}, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic rd_req(input logic [7:0] idx);
        do_req(idx, 1'b0, 1'b1, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] idx;
        bit v0, v1;
        logic [7:0] i0, i1;
        cpu_valid = 1'b0; cpu_index = 8'd0; cpu_write = 1'b0; cpu_read = 1'b0;
        cpu_wdata = 9'd0; dp_valid = 1'b0; dp_index = 8'd0;
        model_clear();
        rst = 1'b0;
        repeat (3) @(negedge clk_cp);
        check("rst_ready", 32'(out_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_val", 32'(out_val), 32'd0);
        rst = 1'b1;
        @(negedge clk_cp);

        // Basic write-ack then read back.
        wr_req(8'h00, 8'd5); wr_req(8'h01, 8'd3); wr_req(8'h02, 8'd2);
        wr_req(8'h20, 8'd1); wr_req(8'h21, 8'd1); wr_req(8'h22, 8'd1);
        rd_req(8'h00); check("p0c0_const", 32'(got_val), 32'({11'd0, 8'd5, 8'd0}));
        rd_req(8'h01); rd_req(8'h02); rd_req(8'h20); rd_req(8'h21); rd_req(8'h22);

        // Three consumes: reload to 5 with round 1, then 4, then 3.
        wr_req(8'h00, 8'd5);
        repeat (3) cycle(1'b1, 8'h00, 1'b0, 8'd0, 8'd0);
        rd_req(8'h00); check("consume3_const", 32'(got_val), 32'({11'd1, 8'd5, 8'd3}));

        // Out of range read, consume and storage untouched.
        rd_req(8'h08); check("oor_const", 32'(got_val), 32'h7FFFFFF);
        cycle(1'b1, 8'h09, 1'b0, 8'd0, 8'd0);
        rd_req(8'h00); check("oor_no_change", 32'(got_val), 32'({11'd1, 8'd5, 8'd3}));
        do_req(8'h1F, 1'b1, 1'b0, 9'h0FF, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

        // Collision: write wins over same-cycle consume; different entry still consumed.
        wr_req(8'h20, 8'd1);
        do_req(8'h20, 1'b1, 1'b0, 9'h001, 1'b0, 8'd0, 1'b1, 8'h20, 1'b0);
        rd_req(8'h20); check("collision_const", 32'(got_val), 32'({11'd0, 8'd1, 8'd0}));
        do_req(8'h21, 1'b1, 1'b0, 9'h102, 1'b0, 8'd0, 1'b1, 8'h22, 1'b0);
        rd_req(8'h22); check("diff_entry_const", 32'(got_val), 32'({11'd1, 8'd1, 8'd1}));

        // Request spam while busy, and read+write treated as write.
        do_req(8'h02, 1'b0, 1'b1, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        rd_req(8'h03); check("spam_not_applied", 32'(got_val), 32'd0);
        do_req(8'h04, 1'b1, 1'b1, 9'h077, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check("rdwr_is_write", 32'(got_val), 32'({11'd0, 8'h77, 8'd0}));

        // Round counter wrap on a weight-1 entry.
        wr_req(8'h43, 8'd1);
        repeat (2047) cycle(1'b1, 8'h43, 1'b0, 8'd0, 8'd0);
        rd_req(8'h43); check("round_max", 32'(got_val), 32'({11'h7FF, 8'd1, 8'd1}));
        cycle(1'b1, 8'h43, 1'b0, 8'd0, 8'd0);
        rd_req(8'h43); check("round_wrap", 32'(got_val), 32'({11'd0, 8'd1, 8'd1}));

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            idx = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 9))};
            rand_dp(v0, i0);
            rand_dp(v1, i1);
            do_req(idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom),
                   v0, i0, v1, i1, 1'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                rand_dp(v0, i0);
                cycle(v0, i0, 1'b0, 8'd0, 8'd0);
            end
        end

        // Reset during ACCESS aborts the transaction and clears the table.
        wr_req(8'h00, 8'd9);
        cpu_valid = 1'b1; cpu_index = 8'h01; cpu_write = 1'b1; cpu_read = 1'b0; cpu_wdata = 9'h033;
        cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        cpu_valid = 1'b0; cpu_write = 1'b0;
        rst = 1'b0;
        #1;
        model_clear();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(out_ready), 32'd1);
        @(negedge clk_cp);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        rd_req(8'h00); check("post_rst_p0c0", 32'(got_val), 32'd0);
        rd_req(8'h01); check("post_rst_p0c1", 32'(got_val), 32'd0);
        rd_req(8'h43); check("post_rst_p2c3", 32'(got_val), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
